fc_seq_ctrl: RTL and testbench
==============================

Name: fc_seq_ctrl

Overview:
- Sequencer for a fully-connected layer computed serially: one shared signed multiplier plus one accumulator are time-multiplexed across all output neurons.
- Reads activations and weights from external synchronous memories, accumulates IN products per neuron, then applies ReLU.
- Emits one result per neuron over a valid/ready handshake.
- Sits between the pooled-feature buffer and the next layer's input buffer. It is the area-lean alternative to the fully parallel per-neuron adder-tree layer.

Parameters:
- WIDTH, 8, bit width of activations and weights (signed two's complement).
- IN, 400, number of inputs per neuron.
- OUT, 120, number of output neurons.
- ACC_W, WIDTH*2+$clog2(IN), accumulator and result width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  1-cycle pulse; begins a layer pass when idle.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  1-cycle pulse after the last neuron's result is accepted.
- act_rd  output  1  activation memory read enable.
- act_addr  output  $clog2(IN)  activation index i.
- act_rdata  input  WIDTH  activation data, valid 1 cycle after act_rd.
- w_rd  output  1  weight memory read enable (always equal to act_rd).
- w_addr  output  $clog2(IN*OUT)  weight index n*IN+i.
- w_rdata  input  WIDTH  weight data, valid 1 cycle after w_rd.
- z_valid  output  1  result valid.
- z_ready  input  1  downstream accept.
- z_data  output  ACC_W  ReLU'd neuron result.
- z_idx  output  $clog2(OUT)  neuron index n of z_data.

Behaviour:
- Async reset (rst_n=0) forces immediately:
  - state=IDLE; busy=0, done=0, act_rd=w_rd=0, z_valid=0.
  - act_addr, w_addr, z_data, z_idx, accumulator, product register, and i/n counters all 0.
  - Reset asserted mid-pass abandons the pass with no partial output. After release, the block waits for a new start.
- States: IDLE, ISSUE, DRAIN, PRESENT, FIN.
- IDLE: start=1 -> ISSUE, with n=0, i=0, w_addr=0, accumulator=0. Any other input is ignored.
- ISSUE: one read per cycle.
  - act_rd=w_rd=1, act_addr=i, w_addr=n*IN+i. w_addr is a running counter; no multiplier is used for it.
  - i increments each cycle. On the cycle issuing i=IN-1 -> DRAIN.
- Pipeline, for a read issued in cycle k:
  - Data is present at k+1; prod = signed(act_rdata)*signed(w_rdata) is registered at the end of k+1.
  - acc += sign-extended prod at the end of k+2.
  - The accumulator is cleared when the first product of a neuron is added (load instead of add). There is no extra bubble between neurons.
- DRAIN: 2 cycles, act_rd=w_rd=0, then -> PRESENT.
  - Neuron latency is IN+2 cycles from first issue to result ready.
- PRESENT:
  - z_valid=1; z_data = acc[ACC_W-1] ? 0 : acc; z_idx=n.
  - z_data and z_idx are registered and stable while z_valid=1 and z_ready=0.
  - On z_valid&&z_ready: if n==OUT-1 -> FIN; else n++, i=0 -> ISSUE next cycle. w_addr continues from n*IN.
  - z_ready asserted before z_valid has no effect.
- FIN: done=1 for one cycle, busy=0 in that same cycle's next state, -> IDLE.
  - busy is high in ISSUE, DRAIN, PRESENT and FIN, low in IDLE.
  - start in any non-IDLE state is ignored (not queued).
- Arithmetic:
  - The product is 2*WIDTH signed. The accumulator ACC_W signed is sized to hold IN worst-case products without overflow; no saturation logic.
  - -128*-128 and 127*-128 must be exact.
- Total pass length with z_ready tied high: OUT*(IN+3)+1 cycles from start to done.

Test Plan:
- IN=4, OUT=2; acts {1,2,3,4}; weights n0 {1,1,1,1}, n1 {-1,-1,-1,-1}; z_ready=1 -> z(idx0)=10, z(idx1)=0 (ReLU); done pulses exactly 2*(4+3)+1=15 cycles after start.
- Extremes, IN=4, OUT=1: acts all -128, weights all -128 -> z_data=65536. Weights all 127 -> z_data=0. No overflow on ACC_W=18.
- Backpressure: hold z_ready=0 for 10 cycles in PRESENT -> z_valid, z_data and z_idx stay constant, no reads issued. Release -> next neuron begins the following cycle.
- Address check, IN=400, OUT=120: w_addr visits 0..47999 monotonically exactly once; act_addr cycles 0..399 per neuron; act_rd count = 48000.
- start pulsed while busy, and again in the FIN cycle -> ignored, exactly one done per accepted start.
- rst_n dropped mid-ISSUE of neuron 1 -> all outputs 0 asynchronously. After release with no start, the block stays idle with z_valid=0. A new start then yields correct results from neuron 0.

Source files
------------

// File: rtl/fc_seq_ctrl.sv
// Serial fully-connected layer sequencer: one shared signed multiplier and one
// accumulator are time-multiplexed across all output neurons, followed by ReLU.
module fc_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int IN    = 400,
    parameter int OUT   = 120,
    parameter int ACC_W = WIDTH*2 + $clog2(IN)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      act_rd,
    output logic [$clog2(IN)-1:0]     act_addr,
    input  logic [WIDTH-1:0]          act_rdata,
    output logic                      w_rd,
    output logic [$clog2(IN*OUT)-1:0] w_addr,
    input  logic [WIDTH-1:0]          w_rdata,
    output logic                      z_valid,
    input  logic                      z_ready,
    output logic [ACC_W-1:0]          z_data,
    output logic [$clog2(OUT)-1:0]    z_idx
);

    localparam int IW = $clog2(IN);
    localparam int NW = $clog2(OUT);
    localparam int AW = $clog2(IN*OUT);
    localparam int PW = 2*WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        PRESENT,
        FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          i_q, i_d;
    logic [NW-1:0]          n_q, n_d;
    logic [AW-1:0]          w_addr_q, w_addr_d;
    logic                   drain_q, drain_d;

    logic                   rd_vld_q, rd_vld_d;
    logic                   rd_first_q, rd_first_d;
    logic                   prod_vld_q, prod_vld_d;
    logic                   prod_first_q, prod_first_d;
    logic signed [PW-1:0]   prod_q, prod_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0]       z_data_q, z_data_d;
    logic [NW-1:0]          z_idx_q, z_idx_d;

    logic                   issue;
    logic                   clear;
    logic                   z_load;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        n_d      = n_q;
        w_addr_d = w_addr_q;
        drain_d  = 1'b0;
        issue    = 1'b0;
        clear    = 1'b0;
        z_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ISSUE;
                    i_d      = '0;
                    n_d      = '0;
                    w_addr_d = '0;
                    clear    = 1'b1;
                end
            end
            ISSUE: begin
                issue    = 1'b1;
                // Running weight address: n*IN+i without a multiplier.
                w_addr_d = w_addr_q + AW'(1);
                if (i_q == IW'(IN-1)) begin
                    i_d     = '0;
                    state_d = DRAIN;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) begin
                    state_d = PRESENT;
                    z_load  = 1'b1;
                end
            end
            PRESENT: begin
                if (z_ready) begin
                    if (n_q == NW'(OUT-1)) begin
                        state_d = FIN;
                    end else begin
                        n_d     = n_q + NW'(1);
                        state_d = ISSUE;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Two-stage datapath: capture product the cycle after the read, accumulate the next.
    always_comb begin
        rd_vld_d     = issue;
        rd_first_d   = issue && (i_q == '0);
        prod_vld_d   = rd_vld_q;
        prod_first_d = rd_first_q;
        prod_d       = prod_q;
        if (rd_vld_q) begin
            prod_d = signed'(act_rdata) * signed'(w_rdata);
        end

        prod_ext = {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
        acc_d    = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (prod_vld_q) begin
            // First product of a neuron loads the accumulator, so neurons run back to back.
            acc_d = prod_first_q ? prod_ext : acc_q + prod_ext;
        end

        z_data_d = z_data_q;
        z_idx_d  = z_idx_q;
        if (z_load) begin
            z_data_d = acc_d[ACC_W-1] ? '0 : acc_d;
            z_idx_d  = n_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            i_q          <= '0;
            n_q          <= '0;
            w_addr_q     <= '0;
            drain_q      <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_first_q   <= 1'b0;
            prod_vld_q   <= 1'b0;
            prod_first_q <= 1'b0;
            prod_q       <= '0;
            acc_q        <= '0;
            z_data_q     <= '0;
            z_idx_q      <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            n_q          <= n_d;
            w_addr_q     <= w_addr_d;
            drain_q      <= drain_d;
            rd_vld_q     <= rd_vld_d;
            rd_first_q   <= rd_first_d;
            prod_vld_q   <= prod_vld_d;
            prod_first_q <= prod_first_d;
            prod_q       <= prod_d;
            acc_q        <= acc_d;
            z_data_q     <= z_data_d;
            z_idx_q      <= z_idx_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FIN);
    assign act_rd   = (state_q == ISSUE);
    assign w_rd     = (state_q == ISSUE);
    assign act_addr = i_q;
    assign w_addr   = w_addr_q;
    assign z_valid  = (state_q == PRESENT);
    assign z_data   = z_data_q;
    assign z_idx    = z_idx_q;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Self-checking bench for fc_seq_ctrl: a small instance (IN=4, OUT=2) for directed,
// random and reset tests, and a full-size instance (IN=400, OUT=120) for the address sweep.
module tb_fc_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int S_IN  = 4;
    localparam int S_OUT = 2;
    localparam int S_ACC = WIDTH*2 + $clog2(S_IN);
    localparam int B_IN  = 400;
    localparam int B_OUT = 120;
    localparam int B_ACC = WIDTH*2 + $clog2(B_IN);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- small instance ----------------
    logic                        s_start, s_busy, s_done, s_act_rd, s_w_rd, s_z_valid, s_z_ready;
    logic [$clog2(S_IN)-1:0]     s_act_addr;
    logic [$clog2(S_IN*S_OUT)-1:0] s_w_addr;
    logic [WIDTH-1:0]            s_act_rdata, s_w_rdata;
    logic [S_ACC-1:0]            s_z_data;
    logic [$clog2(S_OUT)-1:0]    s_z_idx;
    logic signed [WIDTH-1:0]     s_act_mem [S_IN];
    logic signed [WIDTH-1:0]     s_w_mem   [S_IN*S_OUT];

    fc_seq_ctrl #(.WIDTH(WIDTH), .IN(S_IN), .OUT(S_OUT)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
        .act_rd(s_act_rd), .act_addr(s_act_addr), .act_rdata(s_act_rdata),
        .w_rd(s_w_rd), .w_addr(s_w_addr), .w_rdata(s_w_rdata),
        .z_valid(s_z_valid), .z_ready(s_z_ready), .z_data(s_z_data), .z_idx(s_z_idx)
    );

    always @(posedge clk) begin
        if (s_act_rd) s_act_rdata <= s_act_mem[s_act_addr];
        if (s_w_rd)   s_w_rdata   <= s_w_mem[s_w_addr];
    end

    function automatic longint s_model(input int n);
        longint sum = 0;
        for (int i = 0; i < S_IN; i++)
            sum += longint'(s_act_mem[i]) * longint'(s_w_mem[n*S_IN+i]);
        return (sum < 0) ? 0 : sum;
    endfunction

    // mode 0: ready always high; 1: random ready; 2: hold ready low 10 cycles per result
    task automatic s_run(input int mode, input bit spam);
        int c, got, stalls, hold, reads;
        bit prev_acc;
        got = 0; stalls = 0; hold = 0; reads = 0; prev_acc = 0;
        s_z_ready = (mode == 0);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        c = 1;
        while (!s_done && c < 2000) begin
            check("busy during pass", s_busy, 1);
            if (prev_acc && got < S_OUT) check("next neuron issues at once", s_act_rd, 1);
            prev_acc = 0;
            if (s_act_rd) begin
                check("act_addr", s_act_addr, reads % S_IN);
                check("w_addr", s_w_addr, reads);
                check("w_rd with act_rd", s_w_rd, 1);
                reads++;
            end else begin
                check("w_rd idle", s_w_rd, 0);
            end
            if (spam) s_start = ($urandom_range(0, 2) == 0);
            if (s_z_valid) begin
                check("no read while presenting", s_act_rd, 0);
                check("z_idx", s_z_idx, got);
                check("z_data", s_z_data, s_model(got));
                case (mode)
                    0:       s_z_ready = 1'b1;
                    1:       s_z_ready = 1'($urandom_range(0, 1));
                    default: s_z_ready = (hold == 10);
                endcase
                if (s_z_ready) begin
                    got++; hold = 0; prev_acc = 1;
                end else begin
                    hold++; stalls++;
                end
            end else begin
                s_z_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            c++;
        end
        check("done seen", s_done, 1);
        check("pass length", c, S_OUT*(S_IN+3) + 1 + stalls);
        check("results delivered", got, S_OUT);
        check("reads issued", reads, S_IN*S_OUT);
        if (spam) s_start = 1'b1;
        s_z_ready = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("idle after done", s_busy, 0);
            check("single done pulse", s_done, 0);
            @(negedge clk);
        end
    endtask

    task automatic s_check_zero(input string tag);
        check({tag, " busy"}, s_busy, 0);
        check({tag, " done"}, s_done, 0);
        check({tag, " act_rd"}, s_act_rd, 0);
        check({tag, " w_rd"}, s_w_rd, 0);
        check({tag, " act_addr"}, s_act_addr, 0);
        check({tag, " w_addr"}, s_w_addr, 0);
        check({tag, " z_valid"}, s_z_valid, 0);
        check({tag, " z_data"}, s_z_data, 0);
        check({tag, " z_idx"}, s_z_idx, 0);
    endtask

    // ---------------- full-size instance ----------------
    logic                          b_start, b_busy, b_done, b_act_rd, b_w_rd, b_z_valid, b_z_ready;
    logic [$clog2(B_IN)-1:0]       b_act_addr;
    logic [$clog2(B_IN*B_OUT)-1:0] b_w_addr;
    logic [WIDTH-1:0]              b_act_rdata, b_w_rdata;
    logic [B_ACC-1:0]              b_z_data;
    logic [$clog2(B_OUT)-1:0]      b_z_idx;
    logic signed [WIDTH-1:0]       b_act_mem [B_IN];
    logic signed [WIDTH-1:0]       b_w_mem   [B_IN*B_OUT];

    fc_seq_ctrl #(.WIDTH(WIDTH), .IN(B_IN), .OUT(B_OUT)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .act_rd(b_act_rd), .act_addr(b_act_addr), .act_rdata(b_act_rdata),
        .w_rd(b_w_rd), .w_addr(b_w_addr), .w_rdata(b_w_rdata),
        .z_valid(b_z_valid), .z_ready(b_z_ready), .z_data(b_z_data), .z_idx(b_z_idx)
    );

    always @(posedge clk) begin
        if (b_act_rd) b_act_rdata <= b_act_mem[b_act_addr];
        if (b_w_rd)   b_w_rdata   <= b_w_mem[b_w_addr];
    end

    function automatic longint b_model(input int n);
        longint sum = 0;
        for (int i = 0; i < B_IN; i++)
            sum += longint'(b_act_mem[i]) * longint'(b_w_mem[n*B_IN+i]);
        return (sum < 0) ? 0 : sum;
    endfunction

    task automatic b_run();
        int c, reads, got, addr_bad;
        reads = 0; got = 0; addr_bad = 0;
        b_z_ready = 1'b1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        c = 1;
        while (!b_done && c < 60000) begin
            if (b_act_rd) begin
                if (int'(b_w_addr) != reads || int'(b_act_addr) != reads % B_IN || !b_w_rd)
                    addr_bad++;
                reads++;
            end
            if (b_z_valid) begin
                check("big z_idx", b_z_idx, got);
                check("big z_data", b_z_data, b_model(got));
                got++;
            end
            @(negedge clk);
            c++;
        end
        check("big done seen", b_done, 1);
        check("big address sequence errors", addr_bad, 0);
        check("big reads issued", reads, B_IN*B_OUT);
        check("big results delivered", got, B_OUT);
        check("big pass length", c, B_OUT*(B_IN+3) + 1);
    endtask

    // ---------------- sequence ----------------
    initial begin
        s_start = 1'b0; s_z_ready = 1'b0;
        b_start = 1'b0; b_z_ready = 1'b1;
        for (int i = 0; i < B_IN; i++) b_act_mem[i] = WIDTH'($urandom);
        for (int i = 0; i < B_IN*B_OUT; i++) b_w_mem[i] = WIDTH'($urandom);
        for (int i = 0; i < S_IN; i++) begin
            s_act_mem[i] = WIDTH'(i + 1);
            s_w_mem[i] = 8'sd1;
            s_w_mem[S_IN+i] = -8'sd1;
        end
        repeat (3) @(negedge clk);
        s_check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // acts {1,2,3,4}: neuron0 -> 10, neuron1 -> 0 after ReLU, 15 cycles to done
        s_run(0, 1'b0);

        // extremes: -128*-128 summed four times and 127*-128 summed four times
        for (int i = 0; i < S_IN; i++) begin
            s_act_mem[i] = -8'sd128;
            s_w_mem[i] = -8'sd128;
            s_w_mem[S_IN+i] = 8'sd127;
        end
        check("extreme model sanity", s_model(0), 65536);
        s_run(2, 1'b0);

        // reset during neuron 1 issue while z_data still holds 65536
        s_z_ready = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int k = 0; k < 200 && !(s_act_rd && int'(s_w_addr) == S_IN+1); k++) @(negedge clk);
        check("reached neuron 1 issue", s_w_addr, S_IN+1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 s_check_zero("async reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("stays idle after reset", s_busy, 0);
            check("no result after reset", s_z_valid, 0);
            check("no reads after reset", s_act_rd, 0);
            @(negedge clk);
        end
        s_run(0, 1'b0);

        // randomized data, random backpressure, start pulses while busy
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < S_IN; i++) s_act_mem[i] = WIDTH'($urandom);
            for (int i = 0; i < S_IN*S_OUT; i++) s_w_mem[i] = WIDTH'($urandom);
            if (p % 4 == 0) s_act_mem[$urandom_range(0, S_IN-1)] = -8'sd128;
            s_run(p % 3, p[0]);
        end

        b_run();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
